ram_port_arbiter: RTL and testbench

Shares one single-port block RAM (default 32 x 8) between two requesters using round-robin arbitration, with an optional bus-lock for atomic bursts. It sits between two client engines (e.g. a pattern writer and a checker/readback engine) and the RAM IP. It drives the RAM's `ram_en`/`ram_we`/`ram_addr`/`ram_wr_data` pins and returns `ram_rd_data` to the owning requester with a tagged valid strobe.

---
 rtl/ram_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port block RAM, with bus-lock.
// Define RAM_ARB_RR_EN for round-robin priority; otherwise port 0 wins ties.
module ram_port_arbiter #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wr_data,
    input  logic [DW-1:0] ram_rd_data
);

    typedef enum logic [1:0] {
        IDLE,
        LOCK0,
        LOCK1
    } state_t;

    state_t state_q, state_d;
    logic   xfer0, xfer1;
    logic   rd_pend_q, rd_tag_q;
    logic   rv_q, rv_tag_q;

`ifdef RAM_ARB_RR_EN
    logic prio_q, prio_d;
`endif

    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        state_d = state_q;
`ifdef RAM_ARB_RR_EN
        prio_d  = prio_q;
`endif
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (req0 && req1) begin
`ifdef RAM_ARB_RR_EN
                        gnt0 = !prio_q;
                        gnt1 = prio_q;
`else
                        gnt0 = 1'b1;
`endif
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                end
                LOCK0:   gnt0 = req0;
                LOCK1:   gnt1 = req1;
                default: ;
            endcase
        end
        xfer0 = req0 && gnt0;
        xfer1 = req1 && gnt1;

        // A lock owner dropping its request releases the bus without a transfer
        unique case (state_q)
            IDLE: begin
                if (xfer0 && lock0)
                    state_d = LOCK0;
                else if (xfer1 && lock1)
                    state_d = LOCK1;
            end
            LOCK0: begin
                if (!req0 || !lock0)
                    state_d = IDLE;
            end
            LOCK1: begin
                if (!req1 || !lock1)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef RAM_ARB_RR_EN
        if (xfer0)
            prio_d = 1'b1;
        else if (xfer1)
            prio_d = 1'b0;
        else if (state_q == LOCK0 && !req0)
            prio_d = 1'b1;
        else if (state_q == LOCK1 && !req1)
            prio_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
`ifdef RAM_ARB_RR_EN
            prio_q      <= 1'b0;
`endif
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wr_data <= '0;
            rd_pend_q   <= 1'b0;
            rd_tag_q    <= 1'b0;
            rv_q        <= 1'b0;
            rv_tag_q    <= 1'b0;
        end else begin
            state_q <= state_d;
`ifdef RAM_ARB_RR_EN
            prio_q  <= prio_d;
`endif
            if (xfer0 || xfer1) begin
                ram_en      <= 1'b1;
                ram_we      <= xfer1 ? we1 : we0;
                ram_addr    <= xfer1 ? addr1 : addr0;
                ram_wr_data <= xfer1 ? wdata1 : wdata0;
            end else begin
                ram_en <= 1'b0;
                ram_we <= 1'b0;
            end
            rd_pend_q <= (xfer0 && !we0) || (xfer1 && !we1);
            rd_tag_q  <= xfer1;
            rv_q      <= rd_pend_q;
            rv_tag_q  <= rd_tag_q;
        end
    end

    assign rvalid0 = rv_q && !rv_tag_q;
    assign rvalid1 = rv_q && rv_tag_q;
    assign rdata   = ram_rd_data;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: vector table, directed corner cases and
// randomized traffic against a transaction-level model with a shadow RAM.
module tb_ram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1, lock0, lock1;
    logic [4:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata;
    logic       ram_en, ram_we;
    logic [4:0] ram_addr;
    logic [7:0] ram_wr_data;
    logic [7:0] ram_rd_data;

    always #5 clk = ~clk;

    ram_port_arbiter #(.AW(5), .DW(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
    );

    // Behavioural single-port RAM, preloaded with mem[i] = i
    logic       preload;
    logic [7:0] mem [32];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'(i);
            ram_rd_data <= 8'h00;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wr_data;
            else ram_rd_data <= mem[ram_addr];
        end
    end

    // Reference model state
    typedef struct {
        int         port;
        logic [7:0] data;
        int         due;
    } rd_t;

    int         checks = 0;
    int         failures = 0;
    int         owner;
    bit         prio;
    int         ecnt;
    bit         exp_en, exp_we;
    logic [4:0] exp_addr;
    logic [7:0] exp_wd;
    logic [7:0] shadow [32];
    rd_t        rq [$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void mgrant(output bit g0, output bit g1);
        g0 = 1'b0;
        g1 = 1'b0;
        if (rst) return;
        if (owner == 0) g0 = req0;
        else if (owner == 1) g1 = req1;
        else if (req0 && req1) begin
`ifdef RAM_ARB_RR_EN
            if (prio) g1 = 1'b1;
            else g0 = 1'b1;
`else
            g0 = 1'b1;
`endif
        end else begin
            g0 = req0;
            g1 = req1;
        end
    endfunction

    // One clock: inputs already set after a falling edge
    task automatic step();
        bit         g0, g1, w, lk;
        int         n;
        logic [4:0] a;
        logic [7:0] d;
        bit         ev0, ev1;
        #1;
        mgrant(g0, g1);
        chk("gnt0", gnt0, g0);
        chk("gnt1", gnt1, g1);
        chk("ram_en", ram_en, exp_en);
        chk("ram_we", ram_we, exp_we);
        chk("ram_addr", ram_addr, exp_addr);
        chk("ram_wr_data", ram_wr_data, exp_wd);
        ev0 = 1'b0;
        ev1 = 1'b0;
        if (rq.size() > 0 && rq[0].due == ecnt) begin
            ev0 = (rq[0].port == 0);
            ev1 = (rq[0].port == 1);
        end
        chk("rvalid0", rvalid0, ev0);
        chk("rvalid1", rvalid1, ev1);
        if (ev0 || ev1) begin
            chk("rdata", rdata, rq[0].data);
            void'(rq.pop_front());
        end
        if (rst) begin
            owner    = -1;
            prio     = 1'b0;
            exp_en   = 1'b0;
            exp_we   = 1'b0;
            exp_addr = '0;
            exp_wd   = '0;
            rq.delete();
        end else if ((req0 && g0) || (req1 && g1)) begin
            n  = (req1 && g1) ? 1 : 0;
            w  = n ? we1 : we0;
            a  = n ? addr1 : addr0;
            d  = n ? wdata1 : wdata0;
            lk = n ? lock1 : lock0;
            exp_en   = 1'b1;
            exp_we   = w;
            exp_addr = a;
            exp_wd   = d;
            if (w) shadow[a] = d;
            else rq.push_back('{port: n, data: shadow[a], due: ecnt + 2});
            owner = lk ? n : -1;
            prio  = (n == 0);
        end else begin
            exp_en = 1'b0;
            exp_we = 1'b0;
            if (owner >= 0 && !((owner == 0) ? req0 : req1)) begin
                prio  = (owner == 0);
                owner = -1;
            end
        end
        ecnt++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_in();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    typedef struct {
        bit r0, r1, l0, l1;
        bit g0_rr, g1_rr, g0_fx, g1_fx;
    } vec_t;

    vec_t vt [11];
    int   n1;

    initial begin
        vt[0]  = '{1,0,0,0, 1,0, 1,0};
        vt[1]  = '{1,1,0,0, 0,1, 1,0};
        vt[2]  = '{1,1,0,0, 1,0, 1,0};
        vt[3]  = '{0,1,0,0, 0,1, 0,1};
        vt[4]  = '{0,0,0,0, 0,0, 0,0};
        vt[5]  = '{0,1,0,1, 0,1, 0,1};
        vt[6]  = '{1,1,0,1, 0,1, 0,1};
        vt[7]  = '{1,1,0,0, 0,1, 0,1};
        vt[8]  = '{1,1,1,0, 1,0, 1,0};
        vt[9]  = '{0,1,0,0, 0,0, 0,0};
        vt[10] = '{1,1,0,0, 0,1, 1,0};

        idle_in();
        rst = 1;
        preload = 1;
        owner = -1;
        prio = 0;
        ecnt = 0;
        exp_en = 0; exp_we = 0; exp_addr = '0; exp_wd = '0;
        for (int i = 0; i < 32; i++) shadow[i] = 8'(i);
        @(posedge clk);
        @(negedge clk);
        preload = 0;

        // Reset state with requests pending
        req0 = 1; req1 = 1;
        step();
        step();
        rst = 0;
        idle_in();

        // Grant vector table
        for (int i = 0; i < 11; i++) begin
            req0 = vt[i].r0; req1 = vt[i].r1;
            lock0 = vt[i].l0; lock1 = vt[i].l1;
            addr0 = 5'(i); addr1 = 5'(i + 16);
            #1;
`ifdef RAM_ARB_RR_EN
            chk("tbl_gnt0", gnt0, vt[i].g0_rr);
            chk("tbl_gnt1", gnt1, vt[i].g1_rr);
`else
            chk("tbl_gnt0", gnt0, vt[i].g0_fx);
            chk("tbl_gnt1", gnt1, vt[i].g1_fx);
`endif
            step();
        end
        idle_in();
        step();
        step();

        // Port 0 writes addr 0..31 with data = addr
        for (int i = 0; i < 32; i++) begin
            req0 = 1; we0 = 1; addr0 = 5'(i); wdata0 = 8'(i);
            #1;
            chk("wr_gnt0", gnt0, 1'b1);
            step();
        end
        idle_in();
        step();

        // Both ports read continuously
        n1 = 0;
        for (int i = 0; i < 8; i++) begin
            req0 = 1; req1 = 1; addr0 = 5'd3; addr1 = 5'd7;
            #1;
            if (gnt1) n1++;
            step();
        end
        idle_in();
        step();
        step();
        step();
`ifdef RAM_ARB_RR_EN
        chk("alt_gnt1_count", n1, 4);
`else
        chk("alt_gnt1_count", n1, 0);
`endif

        // Port 1 locked burst while port 0 waits
        for (int i = 0; i < 5; i++) begin
            req1 = 1; we1 = 1; lock1 = (i < 4); addr1 = 5'(i + 20);
            wdata1 = 8'(8'hA0 + i);
            req0 = (i > 0); addr0 = 5'd9;
            #1;
            chk("lock_gnt0", gnt0, 1'b0);
            chk("lock_gnt1", gnt1, 1'b1);
            step();
        end
        req1 = 0; lock1 = 0; we1 = 0;
        #1;
        chk("unlock_gnt0", gnt0, 1'b1);
        step();
        idle_in();
        step();
        step();

        // Locked read, then reset on the following edge
        req0 = 1; lock0 = 1; addr0 = 5'd3;
        step();
        rst = 1; req1 = 1;
        #1;
        chk("rst_gnt0", gnt0, 1'b0);
        chk("rst_gnt1", gnt1, 1'b0);
        step();
        rst = 0; idle_in();
        req1 = 1; addr1 = 5'd7;
        #1;
        chk("post_rst_rvalid0", rvalid0, 1'b0);
        chk("post_rst_ram_en", ram_en, 1'b0);
        chk("post_rst_gnt1", gnt1, 1'b1);
        step();
        idle_in();
        step();
        step();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst    = ($urandom_range(0, 49) == 0);
            req0   = 1'($urandom_range(0, 2) != 0);
            req1   = 1'($urandom_range(0, 2) != 0);
            we0    = 1'($urandom);
            we1    = 1'($urandom);
            lock0  = ($urandom_range(0, 3) == 0);
            lock1  = ($urandom_range(0, 3) == 0);
            addr0  = 5'($urandom);
            addr1  = 5'($urandom);
            wdata0 = 8'($urandom);
            wdata1 = 8'($urandom);
            step();
        end
        rst = 0;
        idle_in();
        step();
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
